ks_vandana_fp_mul_seq: RTL

- Iterative IEEE-754 single-precision multiplier. It is the inverse-operation companion to the team's FP divider: the divider computes a/b, this block computes a*b.
- Uses a shift-and-add datapath (one partial product per cycle) instead of a full array multiplier.
- Valid/ready handshake on both input and output, so it can sit in the same FP datapath behind an operand-issue stage and in front of a result consumer.
- Mantissa rounding is truncation; the exponent path is extended to detect overflow and underflow.

---
 rtl/ks_vandana_fp_mul_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ks_vandana_fp_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier: shift-and-add significand product,
// one partial product per cycle, truncating rounding, valid/ready on both sides.
module ks_vandana_fp_mul_seq #(
  parameter int MANT_W   = 24,
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_s;
  logic [MANT_W-1:0]     r_ma;
  logic [MANT_W-1:0]     r_mb;
  logic signed [9:0]     r_e;
  logic                  r_zero_a, r_zero_b, r_inf_a, r_inf_b;
  logic [2*MANT_W-1:0]   r_p;
  logic [4:0]            r_k;
  logic [31:0]           r_c;

  logic                  w_accept;
  logic                  w_handoff;
  logic signed [9:0]     w_e_sum;
  logic [2*MANT_W-1:0]   w_pp;
  logic signed [9:0]     w_e_norm;
  logic [22:0]           w_mant;
  logic [31:0]           w_c_norm;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign c         = r_c;

  assign w_accept  = in_valid && in_ready;
  assign w_handoff = out_valid && out_ready;

  // 10-bit signed so that sums below zero and above 255 survive for the range checks
  assign w_e_sum = $signed({2'b00, a1[30:23]}) + $signed({2'b00, b1[30:23]})
                   - 10'(EXP_BIAS);

  assign w_pp = r_mb[r_k] ? ({{MANT_W{1'b0}}, r_ma} << r_k) : '0;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = MUL;
      MUL:  if (r_k == 5'(MANT_W - 1)) w_state_next = NORM;
      NORM: w_state_next = DONE;
      DONE: if (w_handoff) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_e_norm = r_p[2*MANT_W-1] ? r_e + 10'sd1 : r_e;
    w_mant   = r_p[2*MANT_W-1] ? r_p[46:24] : r_p[45:23];
    // Special classes take priority over the range checks; NaN inputs behave as infinity
    if ((r_zero_a && r_inf_b) || (r_inf_a && r_zero_b))
      w_c_norm = 32'h7FC0_0000;
    else if (r_inf_a || r_inf_b)
      w_c_norm = {r_s, 8'hFF, 23'h0};
    else if (r_zero_a || r_zero_b)
      w_c_norm = {r_s, 31'h0};
    else if (w_e_norm >= 10'sd255)
      w_c_norm = {r_s, 8'hFF, 23'h0};
    else if (w_e_norm <= 10'sd0)
      w_c_norm = {r_s, 31'h0};
    else
      w_c_norm = {r_s, w_e_norm[7:0], w_mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= 1'b0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_e      <= '0;
      r_zero_a <= 1'b0;
      r_zero_b <= 1'b0;
      r_inf_a  <= 1'b0;
      r_inf_b  <= 1'b0;
      r_p      <= '0;
      r_k      <= '0;
      r_c      <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_s      <= a1[31] ^ b1[31];
            r_ma     <= {1'b1, a1[22:0]};
            r_mb     <= {1'b1, b1[22:0]};
            r_e      <= w_e_sum;
            r_zero_a <= (a1[30:23] == 8'h00);
            r_zero_b <= (b1[30:23] == 8'h00);
            r_inf_a  <= (a1[30:23] == 8'hFF);
            r_inf_b  <= (b1[30:23] == 8'hFF);
            r_p      <= '0;
            r_k      <= '0;
          end
        end
        MUL: begin
          r_p <= r_p + w_pp;
          r_k <= r_k + 5'd1;
        end
        NORM: r_c <= w_c_norm;
        default: ;
      endcase
    end
  end

endmodule
